// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Slave end of the MEM-stage data memory port. Holds a word-organised array
// with byte-lane write enables and answers each accepted access after a
// fixed number of wait cycles with a single-cycle ready pulse.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   DataMem_access   request valid (MemR or MemW of the MEM stage)
//   DataMem_RW       1 = write, 0 = read
//   DataMem_Address  byte address; word index = Address[log2(DEPTH)+1:2]
//   DataMem_Select   byte-lane enables, bit i covers data bits [8i+7:8i]
//   WriteDataMem     lane-aligned write data
//   ReadDataMem      full word read result (registered, held between reads)
//   DataMem_Ready    one-cycle completion pulse (registered)
//   DataMem_Error    out-of-range flag, coincident with Ready (registered)
//
// Build option
//   DMEM_ADDR_ERR_EN  when defined, a request with non-zero address bits
//                     above the array index is flagged out of range: no
//                     write, read data forced to zero, Error raised with
//                     Ready. When undefined, upper bits are ignored (the
//                     array aliases modulo DEPTH) and Error is tied low.
//
// FSM states
//   state | meaning
//   IDLE  | waiting for DataMem_access; latches the request on acceptance
//   WAIT  | counting wait cycles on the latched request
//   RESP  | array access committed on entry; Ready high for this cycle
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               DataMem_access,
    input  logic               DataMem_RW,
    input  logic [31:0]        DataMem_Address,
    input  logic [WIDTH/8-1:0] DataMem_Select,
    input  logic [WIDTH-1:0]   WriteDataMem,
    output logic [WIDTH-1:0]   ReadDataMem,
    output logic               DataMem_Ready,
    output logic               DataMem_Error
);

    localparam int         NB       = WIDTH / 8;
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam bit         SINGLE   = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [NB-1:0]     sel_q, sel_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              ready_q, ready_d;

    logic              commit;
    logic              blocked;
    logic              mem_we;

    logic [WIDTH-1:0]  mem_q [DEPTH];

`ifdef DMEM_ADDR_ERR_EN
    logic              oor_q, oor_d;
    logic              err_q, err_d;
    logic [1:0]        unused_addr_bits;

    assign unused_addr_bits = DataMem_Address[1:0];
`else
    logic [31-AW:0]    unused_addr_bits;

    assign unused_addr_bits = {DataMem_Address[31:AW+2], DataMem_Address[1:0]};
`endif

    // Next-state logic. In IDLE the *_d request fields carry the incoming
    // request, elsewhere they carry the latched one, so the commit path can
    // use them uniformly (this is what makes LATENCY=1 work without a WAIT).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        commit  = 1'b0;
        blocked = 1'b0;
        mem_we  = 1'b0;
`ifdef DMEM_ADDR_ERR_EN
        oor_d   = oor_q;
        err_d   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (DataMem_access) begin
                    addr_d  = DataMem_Address[AW+1:2];
                    rw_d    = DataMem_RW;
                    sel_d   = DataMem_Select;
                    wdata_d = WriteDataMem;
                    cnt_d   = CNT_LOAD;
`ifdef DMEM_ADDR_ERR_EN
                    oor_d   = |DataMem_Address[31:AW+2];
`endif
                    if (SINGLE) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Terminal count: the counter reaches 0 on this edge.
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                // The request still on the bus here is the retiring one.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DMEM_ADDR_ERR_EN
        blocked = oor_d;
`endif

        if (commit) begin
            ready_d = 1'b1;
            if (blocked) begin
                rdata_d = '0;
`ifdef DMEM_ADDR_ERR_EN
                err_d   = 1'b1;
`endif
            end else if (rw_d) begin
                mem_we = 1'b1;
            end else begin
                rdata_d = mem_q[addr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
`ifdef DMEM_ADDR_ERR_EN
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
`ifdef DMEM_ADDR_ERR_EN
            oor_q   <= oor_d;
            err_q   <= err_d;
`endif
        end
    end

    // Array is not reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (sel_d[i]) begin
                    mem_q[addr_d][8*i +: 8] <= wdata_d[8*i +: 8];
                end
            end
        end
    end

    assign ReadDataMem   = rdata_q;
    assign DataMem_Ready = ready_q;
`ifdef DMEM_ADDR_ERR_EN
    assign DataMem_Error = err_q;
`else
    assign DataMem_Error = 1'b0;
`endif

endmodule
